// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: parity codes, FSM states,
// frame length and baud divisor helpers.
package uart_tx_arbiter_pkg;

    localparam logic [1:0]  PAR_NONE   = 2'b00;
    localparam int unsigned FRAME_BITS = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // Start + 8 data + stop, plus one parity bit when parity is enabled.
    function automatic int unsigned frame_bits(input logic [1:0] par);
        return FRAME_BITS + ((par != PAR_NONE) ? 32'd1 : 32'd0);
    endfunction

    function automatic int unsigned baud_div(input int unsigned base_div, input logic [2:0] code);
        return base_div << code;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module uart_tx_arbiter_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    always_comb begin
        logic [IDX_W-1:0] idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters; times each frame
// internally since the transmitter has no busy/done indication.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned BASE_DIV = 16,
    parameter int unsigned GAP_BITS = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         ack,
    input  logic [2:0]                 baud_rate,
    input  logic [1:0]                 parity,
    output logic [7:0]                 tx_data,
    output logic                       tx_activate,
    output logic [2:0]                 tx_baud_rate,
    output logic [1:0]                 tx_parity,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned DIV_W = $clog2(BASE_DIV) + 8;
    localparam int unsigned CNT_W = 8;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               tx_activate_q, tx_activate_d;
    logic               busy_q, busy_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [2:0]         tx_baud_rate_q, tx_baud_rate_d;
    logic [1:0]         tx_parity_q, tx_parity_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;

    logic [NUM_REQ-1:0] gnt_onehot;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic [7:0]         gnt_byte;
    logic [DIV_W-1:0]   reload_div;
    logic               frame_done;

    uart_tx_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req         (req),
        .rr_ptr      (rr_ptr_q),
        .grant       (gnt_onehot),
        .grant_idx   (gnt_idx),
        .grant_valid (gnt_valid)
    );

    // Byte of the requester selected this cycle.
    always_comb begin
        gnt_byte = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) gnt_byte = req_data[8*i +: 8];
        end
    end

    assign reload_div = DIV_W'(baud_div(BASE_DIV, tx_baud_rate_q) - 32'd1);

    // The transmitter starts its frame on the cycle after it sees tx_activate,
    // so bit timing is held during the activate cycle.
    always_comb begin
        state_d        = state_q;
        ack_d          = '0;
        tx_activate_d  = 1'b0;
        busy_d         = busy_q;
        tx_data_d      = tx_data_q;
        tx_baud_rate_d = tx_baud_rate_q;
        tx_parity_d    = tx_parity_q;
        grant_id_d     = grant_id_q;
        rr_ptr_d       = rr_ptr_q;
        bit_cnt_d      = bit_cnt_q;
        div_cnt_d      = div_cnt_q;
        frame_done     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    tx_data_d      = gnt_byte;
                    tx_baud_rate_d = baud_rate;
                    tx_parity_d    = parity;
                    grant_id_d     = gnt_idx;
                    ack_d          = gnt_onehot;
                    busy_d         = 1'b1;
                    state_d        = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_activate_d = 1'b1;
                bit_cnt_d     = CNT_W'(frame_bits(tx_parity_q));
                div_cnt_d     = reload_div;
                state_d       = ST_SEND;
            end
            ST_SEND, ST_GAP: begin
                if (!tx_activate_q) begin
                    if (div_cnt_q != '0) begin
                        div_cnt_d = div_cnt_q - DIV_W'(1);
                    end else begin
                        div_cnt_d = reload_div;
                        if (bit_cnt_q > CNT_W'(1)) begin
                            bit_cnt_d = bit_cnt_q - CNT_W'(1);
                        end else if (state_q == ST_SEND && GAP_BITS != 0) begin
                            bit_cnt_d = CNT_W'(GAP_BITS);
                            state_d   = ST_GAP;
                        end else begin
                            frame_done = 1'b1;
                        end
                    end
                end
            end
        endcase

        // Last granted requester drops to lowest priority for the next round.
        if (frame_done) begin
            busy_d   = 1'b0;
            rr_ptr_d = (grant_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id_q + IDX_W'(1);
            state_d  = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            ack_q          <= '0;
            tx_activate_q  <= 1'b0;
            busy_q         <= 1'b0;
            tx_data_q      <= '0;
            tx_baud_rate_q <= '0;
            tx_parity_q    <= '0;
            grant_id_q     <= '0;
            rr_ptr_q       <= '0;
            bit_cnt_q      <= '0;
            div_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            ack_q          <= ack_d;
            tx_activate_q  <= tx_activate_d;
            busy_q         <= busy_d;
            tx_data_q      <= tx_data_d;
            tx_baud_rate_q <= tx_baud_rate_d;
            tx_parity_q    <= tx_parity_d;
            grant_id_q     <= grant_id_d;
            rr_ptr_q       <= rr_ptr_d;
            bit_cnt_q      <= bit_cnt_d;
            div_cnt_q      <= div_cnt_d;
        end
    end

    assign ack          = ack_q;
    assign tx_activate  = tx_activate_q;
    assign busy         = busy_q;
    assign tx_data      = tx_data_q;
    assign tx_baud_rate = tx_baud_rate_q;
    assign tx_parity    = tx_parity_q;
    assign grant_id     = grant_id_q;

endmodule
